// File: rtl/bcd_seg_scan_if.sv
// Value-transfer bundle between the BCD decoder (master) and the display scanner (slave).
interface bcd_seg_scan_if;
    logic [7:0] data_in;
    logic       load;
    logic       upd_ack;
    logic       bcd_err;

    modport master (
        output data_in,
        output load,
        input  upd_ack,
        input  bcd_err
    );

    modport slave (
        input  data_in,
        input  load,
        output upd_ack,
        output bcd_err
    );
endinterface

// File: rtl/bcd_seg_scan.sv
// Two-digit multiplexed common-anode 7-segment driver with frame-aligned value updates.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero tens digit while keeping its phase active.
module bcd_seg_scan #(
    parameter  int DIV   = 1000,
    localparam int DIV_W = $clog2(DIV) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_seg_scan_if.slave   bus,
    output logic [6:0]      seg,
    output logic [1:0]      an
);

    typedef enum logic {
        PH_UNITS = 1'b0,
        PH_TENS  = 1'b1
    } phase_t;

    phase_t             phase, phase_nxt;
    logic [DIV_W-1:0]   count, count_nxt;
    logic [7:0]         disp_reg, disp_nxt;
    logic [7:0]         pend_reg, pend_nxt;
    logic               pend_flag, pend_flag_nxt;
    logic               upd_ack_q, upd_ack_nxt;
    logic               bcd_err_q, bcd_err_nxt;
    logic [6:0]         seg_nxt;
    logic [1:0]         an_nxt;
    logic               tick;
    logic               boundary;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] tens_decode(input logic [3:0] d);
`ifdef LEADING_ZERO_BLANK_EN
        return (d == 4'd0) ? 7'h7F : seg_decode(d);
`else
        return seg_decode(d);
`endif
    endfunction

    assign tick     = (count == DIV_W'(DIV - 1));
    assign boundary = tick && (phase == PH_TENS);

    // The tens->units transition is the frame boundary; only there may disp_reg change,
    // and seg/an are recomputed from the post-update value so there is no extra latency.
    always_comb begin
        count_nxt     = tick ? '0 : count + 1'b1;
        phase_nxt     = phase;
        disp_nxt      = disp_reg;
        pend_nxt      = pend_reg;
        pend_flag_nxt = pend_flag;
        upd_ack_nxt   = 1'b0;
        seg_nxt       = seg;
        an_nxt        = an;

        if (tick) begin
            phase_nxt = (phase == PH_TENS) ? PH_UNITS : PH_TENS;
        end

        if (boundary) begin
            if (bus.load) begin
                disp_nxt      = bus.data_in;
                pend_flag_nxt = 1'b0;
                upd_ack_nxt   = 1'b1;
            end else if (pend_flag) begin
                disp_nxt      = pend_reg;
                pend_flag_nxt = 1'b0;
                upd_ack_nxt   = 1'b1;
            end
        end else if (bus.load) begin
            pend_nxt      = bus.data_in;
            pend_flag_nxt = 1'b1;
        end

        if (tick) begin
            if (boundary) begin
                an_nxt  = 2'b10;
                seg_nxt = seg_decode(disp_nxt[3:0]);
            end else begin
                an_nxt  = 2'b01;
                seg_nxt = tens_decode(disp_nxt[7:4]);
            end
        end

        bcd_err_nxt = (disp_nxt[7:4] > 4'd9) || (disp_nxt[3:0] > 4'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            phase     <= PH_TENS;
            disp_reg  <= 8'h00;
            pend_reg  <= 8'h00;
            pend_flag <= 1'b0;
            upd_ack_q <= 1'b0;
            bcd_err_q <= 1'b0;
            seg       <= 7'h7F;
            an        <= 2'b11;
        end else begin
            count     <= count_nxt;
            phase     <= phase_nxt;
            disp_reg  <= disp_nxt;
            pend_reg  <= pend_nxt;
            pend_flag <= pend_flag_nxt;
            upd_ack_q <= upd_ack_nxt;
            bcd_err_q <= bcd_err_nxt;
            seg       <= seg_nxt;
            an        <= an_nxt;
        end
    end

    assign bus.upd_ack = upd_ack_q;
    assign bus.bcd_err = bcd_err_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan: DIV=4 instance for the main sequence, DIV=1 instance for reset/bypass corners.
// Expected tens-zero pattern follows LEADING_ZERO_BLANK_EN.
module tb_bcd_seg_scan;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] TENS_ZERO = 7'h7F;
`else
    localparam logic [6:0] TENS_ZERO = 7'h40;
`endif

    logic       clk;
    logic       rst_n4;
    logic       rst_n1;
    logic [6:0] seg4, seg1;
    logic [1:0] an4, an1;

    int vectors     = 0;
    int miscompares = 0;
    int n_idx       = 0;

    bcd_seg_scan_if bus4();
    bcd_seg_scan_if bus1();

    bcd_seg_scan #(.DIV(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n4),
        .bus   (bus4.slave),
        .seg   (seg4),
        .an    (an4)
    );

    bcd_seg_scan #(.DIV(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .bus   (bus1.slave),
        .seg   (seg1),
        .an    (an1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] data, input logic ld);
        bus4.data_in = data;
        bus4.load    = ld;
    endtask

    // Negedge index k is the sample point just after rising edge k since reset release.
    task automatic goto_neg(input int k);
        repeat (k - n_idx) @(negedge clk);
        n_idx = k;
    endtask

    task automatic release_main;
        @(negedge clk);
        rst_n4 = 1'b1;
        n_idx  = 0;
    endtask

    initial begin
        rst_n4 = 1'b0;
        rst_n1 = 1'b0;
        bus4.data_in = 8'h00;
        bus4.load    = 1'b0;
        bus1.data_in = 8'h00;
        bus1.load    = 1'b0;

        // Reset held with a load strobe that must be ignored
        apply_stimulus(8'h99, 1'b1);
        repeat (3) @(negedge clk);
        check_output("rst_an",      {6'b0, an4},          8'h03);
        check_output("rst_seg",     {1'b0, seg4},         8'h7F);
        check_output("rst_upd_ack", {7'b0, bus4.upd_ack}, 8'h00);
        check_output("rst_bcd_err", {7'b0, bus4.bcd_err}, 8'h00);
        apply_stimulus(8'h00, 1'b0);

        release_main();
        goto_neg(3);
        check_output("dark_before_tick", {6'b0, an4}, 8'h03);
        goto_neg(4);
        check_output("first_units_an",  {6'b0, an4},          8'h02);
        check_output("first_units_seg", {1'b0, seg4},         8'h40);
        check_output("first_no_ack",    {7'b0, bus4.upd_ack}, 8'h00);
        goto_neg(8);
        check_output("first_tens_an",  {6'b0, an4},  8'h01);
        check_output("first_tens_seg", {1'b0, seg4}, {1'b0, TENS_ZERO});

        // Mid-frame load of 15
        goto_neg(9);
        apply_stimulus(8'h15, 1'b1);
        goto_neg(10);
        apply_stimulus(8'h00, 1'b0);
        goto_neg(11);
        check_output("load_no_glitch", {1'b0, seg4}, {1'b0, TENS_ZERO});
        goto_neg(12);
        check_output("l15_ack",       {7'b0, bus4.upd_ack}, 8'h01);
        check_output("l15_units_an",  {6'b0, an4},          8'h02);
        check_output("l15_units_seg", {1'b0, seg4},         8'h12);
        goto_neg(13);
        check_output("l15_ack_pulse", {7'b0, bus4.upd_ack}, 8'h00);
        goto_neg(16);
        check_output("l15_tens_an",  {6'b0, an4},  8'h01);
        check_output("l15_tens_seg", {1'b0, seg4}, 8'h79);

        // Two loads in one frame: last one wins
        goto_neg(17);
        apply_stimulus(8'h07, 1'b1);
        goto_neg(18);
        apply_stimulus(8'h09, 1'b1);
        goto_neg(19);
        apply_stimulus(8'h00, 1'b0);
        goto_neg(20);
        check_output("l09_ack",       {7'b0, bus4.upd_ack}, 8'h01);
        check_output("l09_units_seg", {1'b0, seg4},         8'h10);
        goto_neg(21);
        check_output("l09_ack_pulse", {7'b0, bus4.upd_ack}, 8'h00);
        goto_neg(24);
        check_output("l09_tens_seg", {1'b0, seg4}, {1'b0, TENS_ZERO});
        goto_neg(28);
        check_output("l09_single_ack", {7'b0, bus4.upd_ack}, 8'h00);
        check_output("l09_held_seg",   {1'b0, seg4},         8'h10);

        // Invalid nibble then recovery
        goto_neg(29);
        apply_stimulus(8'h1F, 1'b1);
        goto_neg(30);
        apply_stimulus(8'h00, 1'b0);
        goto_neg(36);
        check_output("l1f_units_seg", {1'b0, seg4},         8'h3F);
        check_output("l1f_bcd_err",   {7'b0, bus4.bcd_err}, 8'h01);
        goto_neg(40);
        check_output("l1f_tens_seg", {1'b0, seg4}, 8'h79);
        goto_neg(41);
        apply_stimulus(8'h12, 1'b1);
        goto_neg(42);
        apply_stimulus(8'h00, 1'b0);
        goto_neg(43);
        check_output("l12_err_held", {7'b0, bus4.bcd_err}, 8'h01);
        goto_neg(44);
        check_output("l12_bcd_err",   {7'b0, bus4.bcd_err}, 8'h00);
        check_output("l12_units_seg", {1'b0, seg4},         8'h24);

        // Load exactly on the boundary tick: bypass
        goto_neg(51);
        apply_stimulus(8'h08, 1'b1);
        goto_neg(52);
        apply_stimulus(8'h00, 1'b0);
        check_output("byp_units_seg", {1'b0, seg4},         8'h00);
        check_output("byp_units_an",  {6'b0, an4},          8'h02);
        check_output("byp_ack",       {7'b0, bus4.upd_ack}, 8'h01);
        goto_neg(53);
        check_output("byp_ack_pulse", {7'b0, bus4.upd_ack}, 8'h00);
        goto_neg(56);
        check_output("byp_tens_seg", {1'b0, seg4}, {1'b0, TENS_ZERO});

        // Async reset in a tens phase with a pending value
        goto_neg(57);
        apply_stimulus(8'h33, 1'b1);
        goto_neg(58);
        apply_stimulus(8'h00, 1'b0);
        goto_neg(59);
        #2 rst_n4 = 1'b0;
        #1;
        check_output("arst_an",  {6'b0, an4},  8'h03);
        check_output("arst_seg", {1'b0, seg4}, 8'h7F);
        release_main();
        goto_neg(3);
        check_output("arst_dark", {6'b0, an4}, 8'h03);
        goto_neg(4);
        check_output("arst_pend_lost", {1'b0, seg4},         8'h40);
        check_output("arst_no_ack",    {7'b0, bus4.upd_ack}, 8'h00);

        // DIV=1: every cycle is a tick, first edge is a bypass boundary
        @(negedge clk);
        check_output("d1_rst_an", {6'b0, an1}, 8'h03);
        bus1.data_in = 8'h05;
        bus1.load    = 1'b1;
        rst_n1       = 1'b1;
        @(negedge clk);
        check_output("d1_units_an",  {6'b0, an1},          8'h02);
        check_output("d1_units_seg", {1'b0, seg1},         8'h12);
        check_output("d1_ack",       {7'b0, bus1.upd_ack}, 8'h01);
        bus1.data_in = 8'h77;
        bus1.load    = 1'b1;
        @(negedge clk);
        bus1.load = 1'b0;
        check_output("d1_tens_an",  {6'b0, an1},          8'h01);
        check_output("d1_tens_seg", {1'b0, seg1},         {1'b0, TENS_ZERO});
        check_output("d1_ack_pulse",{7'b0, bus1.upd_ack}, 8'h00);
        #2 rst_n1 = 1'b0;
        #1;
        check_output("d1_arst_an",  {6'b0, an1},  8'h03);
        check_output("d1_arst_seg", {1'b0, seg1}, 8'h7F);
        @(negedge clk);
        rst_n1 = 1'b1;
        @(negedge clk);
        check_output("d1_pend_lost", {1'b0, seg1},         8'h40);
        check_output("d1_no_ack",    {7'b0, bus1.upd_ack}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
